// File: rtl/instr_fetcher.sv
// instr_fetcher: fetch-stage controller. Owns the fetch PC, issues one
// outstanding instruction-cache request at a time, hands the returned word to
// the branch predictor and pushes {instr, pc, taken} into the instruction queue.
// A ROB clear redirects the PC. Any response still in flight is drained.
//
// Build option: define FETCH_PREDICT_EN to follow the predictor's next-PC and
// taken bit. Left undefined, fetch is sequential (pc+4) and the predictor
// inputs are ignored.
module instr_fetcher #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   output logic        ic_req,
   output logic [31:0] ic_addr,
   input  logic        ic_valid,
   input  logic [31:0] ic_instr,
   output logic        pred_instr_valid,
   output logic [31:0] pred_instr,
   output logic [31:0] pred_pc,
   input  logic        pred_jump,
   input  logic [31:0] pred_next_pc,
   input  logic        iq_full,
   output logic        iq_push,
   output logic [31:0] iq_instr,
   output logic [31:0] iq_pc,
   output logic        iq_pred_jump,
   input  logic        rob_clear,
   input  logic [31:0] rob_target_pc
);

   localparam logic [1:0] IDLE  = 2'd0;  // about to issue a request for pc
   localparam logic [1:0] WAIT  = 2'd1;  // request outstanding
   localparam logic [1:0] HOLD  = 2'd2;  // word parked, queue was full
   localparam logic [1:0] DRAIN = 2'd3;  // flushed request, drop its response

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        jump;
   } iq_entry_t;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] hold_instr;
   logic [31:0] next_pc;
   logic        push_jump;
   logic        word_here;
   logic        push_now;
   iq_entry_t   push_entry;

   // A word is available to the predictor either straight off the cache
   // (WAIT with a response) or from the parking register (HOLD).
   assign word_here  = ((state == WAIT) && ic_valid) || (state == HOLD);
   assign pred_pc    = pc;
   assign pred_instr = (state == HOLD) ? hold_instr : ic_instr;

`ifdef FETCH_PREDICT_EN
   assign next_pc          = pred_next_pc;
   assign push_jump        = pred_jump;
   assign pred_instr_valid = word_here;
`else
   // Sequential fetch only; taken branches are repaired by the ROB clear.
   logic unused_pred;
   assign unused_pred      = pred_jump ^ (^pred_next_pc);
   assign next_pc          = pc + 32'd4;
   assign push_jump        = 1'b0;
   assign pred_instr_valid = 1'b0;
`endif

   // A push commits when a word is present, the queue has room on this edge
   // and no flush is in progress. rdy gating is applied in the register block.
   assign push_now = word_here && !iq_full && !rob_clear;

   always_comb begin
      push_entry       = '0;
      push_entry.instr = pred_instr;
      push_entry.pc    = pc;
      push_entry.jump  = push_jump;
   end

   // Queue push port: one-cycle strobe, payload held between pushes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iq_push      <= 1'b0;
         iq_instr     <= 32'h0;
         iq_pc        <= 32'h0;
         iq_pred_jump <= 1'b0;
      end else begin
         iq_push <= rdy && push_now;
         if (rdy && push_now) begin
            iq_instr     <= push_entry.instr;
            iq_pc        <= push_entry.pc;
            iq_pred_jump <= push_entry.jump;
         end
      end
   end

   // Fetch PC: redirect on flush, advance on each committed push.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (rdy) begin
         if (rob_clear)
            pc <= rob_target_pc;
         else if (push_now)
            pc <= next_pc;
      end
   end

   // Parking register for a word that arrived while the queue was full.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_instr <= 32'h0;
      end else if (rdy && !rob_clear && (state == WAIT) && ic_valid && iq_full) begin
         hold_instr <= ic_instr;
      end
   end

   // Fetch FSM and cache request port. A flush wins over everything; a flush
   // with a request still outstanding goes to DRAIN so its response is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         ic_req  <= 1'b0;
         ic_addr <= 32'h0;
      end else if (rdy) begin
         if (rob_clear) begin
            case (state)
               WAIT, DRAIN: begin
                  if (ic_valid) begin
                     ic_req <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     state  <= DRAIN;
                  end
               end
               default: state <= IDLE;
            endcase
         end else begin
            case (state)
               IDLE: begin
                  ic_req  <= 1'b1;
                  ic_addr <= pc;
                  state   <= WAIT;
               end
               WAIT: begin
                  if (ic_valid) begin
                     ic_req <= 1'b0;
                     state  <= iq_full ? HOLD : IDLE;
                  end
               end
               HOLD: begin
                  if (!iq_full)
                     state <= IDLE;
               end
               default: begin
                  if (ic_valid) begin
                     ic_req <= 1'b0;
                     state  <= IDLE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: doc/instr_fetcher.md
# instr_fetcher

Instruction-fetch stage controller for the out-of-order RISC-V core. It owns the architectural fetch PC, requests 32-bit instructions from the instruction cache, and hands each returned word to the branch predictor. It then pushes the instruction, its PC and the predict-taken bit into the instruction queue, and advances the PC to the predictor's next-PC. It also redirects fetch on a ROB misprediction clear, discarding any in-flight cache response.

## Interface
- RESET_PC, 32'h0, fetch PC loaded at reset.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes the block.
- ic_req  out  1  fetch request to the instruction cache; held high until served.
- ic_addr  out  32  fetch address.
- ic_valid  in  1  one-cycle pulse; `ic_instr` is valid.
- ic_instr  in  32  fetched instruction word.
- pred_instr_valid  out  1  predictor inputs are meaningful this cycle.
- pred_instr  out  32  instruction presented to the predictor.
- pred_pc  out  32  PC of that instruction.
- pred_jump  in  1  predictor taken decision (combinational).
- pred_next_pc  in  32  predictor next PC (combinational).
- iq_full  in  1  instruction queue cannot accept a push this cycle.
- iq_push  out  1  one-cycle push strobe.
- iq_instr  out  32  pushed instruction.
- iq_pc  out  32  pushed PC.
- iq_pred_jump  out  1  pushed predicted-taken bit.
- rob_clear  in  1  misprediction flush.
- rob_target_pc  in  32  correct PC accompanying `rob_clear`.

## Operation
- State: `pc` (32 bits); `hold_instr` (32 bits); FSM in {IDLE, WAIT, HOLD, DRAIN}.
- IDLE: set `ic_req` to 1 and `ic_addr` to `pc`; go to WAIT.
- WAIT: keep `ic_req` high.
  - On `ic_valid` with `~iq_full`: clear `ic_req`; push; set `pc` to `pred_next_pc`; go to IDLE.
  - On `ic_valid` with `iq_full`: clear `ic_req`; latch `hold_instr` from `ic_instr`; go to HOLD.
- HOLD: when `~iq_full`, push `hold_instr`, set `pc` to `pred_next_pc`, and go to IDLE.
- DRAIN: keep `ic_req` high; on `ic_valid`, discard the word, clear `ic_req`, and go to IDLE.
- Push: register `iq_push`=1, `iq_instr`, `iq_pc`=`pc`, `iq_pred_jump`=`pred_jump`. `iq_push` is 0 in every cycle without a push.
- Predictor drive (combinational):
  - `pred_pc` = `pc`.
  - `pred_instr` = `hold_instr` in HOLD, otherwise `ic_instr`.
  - `pred_instr_valid` = (WAIT & `ic_valid`) | HOLD.
- `rob_clear` overrides every other action in the same cycle:
  - `pc` takes `rob_target_pc` and no push occurs.
  - WAIT without `ic_valid` goes to DRAIN.
  - WAIT with `ic_valid` (word discarded), HOLD and IDLE all go to IDLE.
  - DRAIN with `ic_valid` goes to IDLE.
  - DRAIN without `ic_valid` stays in DRAIN and updates `pc`.
- `rob_clear` during DRAIN updates `pc` again; the last target wins.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFC + 4 wraps to 0.
- `rdy` low: all registers hold, except that `iq_push` is forced to 0. Inputs are ignored. The cache is frozen by the same `rdy`, so no response is lost.

## Timing
- Reset (async, `rst`=0), all outputs low:
  - FSM=IDLE, `pc`=RESET_PC, `hold_instr`=0.
  - `ic_req`=0, `ic_addr`=0.
  - `iq_push`=0, `iq_instr`=0, `iq_pc`=0, `iq_pred_jump`=0.
- Reset mid-request abandons the request. The cache is reset by the same `rst`.
- First `ic_req` rises on the first posedge after `rst` deasserts (with `rdy` high).
- `ic_valid` on cycle N with queue space: `iq_push` is high in cycle N+1, `ic_req` rises for the next PC in cycle N+2. Minimum 2 cycles per instruction.
- `iq_full` is sampled on the same edge that commits the push.
- A cache response to a flushed request never reaches the queue or the predictor's output path.

## Configuration
- `FETCH_PREDICT_EN` defined:
  - `pc` advances to `pred_next_pc`.
  - `iq_pred_jump` = `pred_jump`.
  - `pred_instr_valid` is driven as described above.
- Undefined:
  - `pc` advances to `pc`+4.
  - `iq_pred_jump` is 0.
  - `pred_instr_valid` is tied 0.
  - `pred_jump` and `pred_next_pc` are ignored; taken branches resolve only via `rob_clear`.

## Test plan
- Reset with RESET_PC=0, cache answering 1 cycle after request, words 0x00000013 (NOP) -> pushes with `iq_pc` 0x0, 0x4, 0x8; `iq_pred_jump`=0 each time.
- Word at PC 0x10 with predictor returning `pred_jump`=1, `pred_next_pc`=0x40 -> push {0x10, taken=1}; next `ic_addr`=0x40.
- `iq_full` high for 3 cycles when `ic_valid` arrives -> FSM=HOLD, no push. Push happens on the first cycle `iq_full` is low, and `ic_req` stays low until then.
- `rob_clear` with `rob_target_pc`=0x200 while in WAIT, `ic_valid` 2 cycles later carrying 0xDEADBEEF -> word never pushed; next `ic_addr`=0x200.
- `rob_clear` coincident with `ic_valid` -> no push, FSM=IDLE, next `ic_addr`=`rob_target_pc`.
- `rdy` low for 4 cycles mid-WAIT -> all outputs frozen and `iq_push`=0; operation resumes with no duplicate push.
